// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the multiply HI/LO sequencing stage.
package mult_pkg;

    localparam int MULT_W = 32;
    localparam int PROD_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sign_fixup.sv
// Combinational sign handling around an unsigned multiplier: operand magnitudes
// going in and a conditional 64-bit two's-complement negate coming out.
module sign_fixup
    import mult_pkg::*;
(
    input  logic [MULT_W-1:0] a,
    input  logic [MULT_W-1:0] b,
    input  logic              neg,
    input  logic [PROD_W-1:0] product,
    output logic [MULT_W-1:0] mag_a,
    output logic [MULT_W-1:0] mag_b,
    output logic [PROD_W-1:0] fixed
);

    // 0x80000000 negates to itself, which read unsigned is the correct magnitude.
    assign mag_a = a[MULT_W-1] ? (~a + MULT_W'(1)) : a;
    assign mag_b = b[MULT_W-1] ? (~b + MULT_W'(1)) : b;
    assign fixed = neg ? (~product + PROD_W'(1)) : product;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequencer between the datapath and mult_64bit: holds operands, waits the fixed
// latency, captures HI/LO. Signed operation is built only when SIGNED_MULT_EN is defined.
module mult_hilo_ctrl
    import mult_pkg::*;
#(
    parameter int MULT_LATENCY = 32,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [MULT_W-1:0] op_a,
    input  logic [MULT_W-1:0] op_b,
    input  logic              op_signed,
    output logic [MULT_W-1:0] mult_a,
    output logic [MULT_W-1:0] mult_b,
    output logic              mult_start,
    input  logic [PROD_W-1:0] mult_product,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [MULT_W-1:0] wr_data,
    output logic [MULT_W-1:0] hi,
    output logic [MULT_W-1:0] lo,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic [MULT_W-1:0] a_sel;
    logic [MULT_W-1:0] b_sel;
    logic [PROD_W-1:0] prod_sel;

    assign last = (state == RUN) && (cnt == CNT_W'(MULT_LATENCY - 1));

`ifdef SIGNED_MULT_EN
    logic              neg;
    logic [MULT_W-1:0] mag_a;
    logic [MULT_W-1:0] mag_b;
    logic [PROD_W-1:0] fixed;

    sign_fixup u_sign_fixup (
        .a       (op_a),
        .b       (op_b),
        .neg     (neg),
        .product (mult_product),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .fixed   (fixed)
    );

    assign a_sel    = op_signed ? mag_a : op_a;
    assign b_sel    = op_signed ? mag_b : op_b;
    assign prod_sel = fixed;

    always_ff @(posedge clk) begin
        if (reset) begin
            neg <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            neg <= op_signed & (op_a[MULT_W-1] ^ op_b[MULT_W-1]);
        end
    end
`else
    logic unused_signed;

    assign unused_signed = op_signed;
    assign a_sel         = op_a;
    assign b_sel         = op_b;
    assign prod_sel      = mult_product;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = RUN;
            RUN:     if (last)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // HI/LO writes are only possible in IDLE, so they never race a capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            mult_a <= '0;
            mult_b <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (state == IDLE) begin
                if (wr_hi) hi <= wr_data;
                if (wr_lo) lo <= wr_data;
                if (req_valid) begin
                    mult_a <= a_sel;
                    mult_b <= b_sel;
                    cnt    <= '0;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (last) begin
                    {hi, lo} <= prod_sel;
                    done     <= 1'b1;
                end
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state == RUN);
    assign mult_start = (state == RUN) && (cnt == '0);

endmodule
